// File: rtl/exact_match_lookup_pkg.sv
// exact_match_lookup_pkg: shared widths, slot layout, FSM states and flow hash
package exact_match_lookup_pkg;
  localparam int ENTRY_WIDTH  = 248;
  localparam int ACTION_WIDTH = 320;
  localparam int HASH_WIDTH   = 15;
  localparam int HASH_CHUNKS  = 18;
  localparam int WORD_ENTRY   = 0;
  localparam int WORD_CNT     = 4;
  localparam int WORD_STAT    = 5;
  localparam int WORD_ACTION  = 6;
  localparam int SLOT_WORDS   = 16;
  localparam int READ_WORDS   = 11;
  localparam int VALID_BIT    = 63;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT_DATA, S_RESULT, S_WAIT_ARB, S_WRITE} state_t;
  function automatic logic [HASH_WIDTH-1:0] flow_hash(input logic [HASH_WIDTH*HASH_CHUNKS-1:0] e);
    logic [HASH_WIDTH-1:0] h;
    h = '0;
    for (int i = 0; i < HASH_CHUNKS; i++) h ^= e[i*HASH_WIDTH +: HASH_WIDTH];
    return h;
  endfunction
endpackage

// File: rtl/exact_match_lookup_fifo.sv
// fallthrough_small_fifo: small request queue whose head is visible while not empty
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_nearly_full,
  output logic             o_empty
);
  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = MAX_DEPTH_BITS + 1;
  logic [WIDTH-1:0]          r_mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic                      w_push, w_pop;
  assign w_push        = i_wr_en && !o_full;
  assign w_pop         = i_rd_en && !o_empty;
  assign o_full        = r_count == CW'(DEPTH);
  assign o_nearly_full = r_count >= CW'(DEPTH - 1);
  assign o_empty       = r_count == '0;
  assign o_dout        = r_mem[r_rd_ptr];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/exact_match_lookup.sv
// exact_match_lookup: hashed exact-match flow table lookup with counter/timestamp write-back
module exact_match_lookup #(
  parameter int ENTRY_WIDTH     = exact_match_lookup_pkg::ENTRY_WIDTH,
  parameter int ACTION_WIDTH    = exact_match_lookup_pkg::ACTION_WIDTH,
  parameter int PKT_SIZE_WIDTH  = 12,
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ENTRY_WIDTH-1:0]           i_flow_entry,
  input  logic                             i_flow_entry_vld,
  input  logic [PKT_SIZE_WIDTH-1:0]        i_pkt_size,
  output logic                             o_exact_match_rdy,
  output logic                             o_exact_hit,
  output logic                             o_exact_miss,
  output logic [ACTION_WIDTH-1:0]          o_exact_data,
  output logic                             o_exact_data_vld,
  input  logic                             i_exact_wins,
  input  logic                             i_exact_loses,
  input  logic [31:0]                      i_openflow_timer,
  output logic                             o_rd_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0]       o_rd_0_addr,
  input  logic                             i_rd_0_ack,
  input  logic                             i_rd_0_vld,
  input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] i_rd_0_data,
  output logic                             o_wr_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0]       o_wr_0_addr,
  output logic [CTRL_WIDTH+DATA_WIDTH-1:0] o_wr_0_data,
  input  logic                             i_wr_0_ack
);
  import exact_match_lookup_pkg::*;
  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int QW = ENTRY_WIDTH + PKT_SIZE_WIDTH;
  state_t                r_state;
  logic [3:0]            r_req_cnt, r_rsp_cnt;
  logic                  r_hit, r_wr_idx;
  logic [AW-1:0]         r_base;
  logic [DATA_WIDTH-1:0] r_slot [READ_WORDS];
  logic [QW-1:0]         w_dout;
  logic [ENTRY_WIDTH-1:0]    w_entry;
  logic [PKT_SIZE_WIDTH-1:0] w_pkt_size;
  logic [4*DATA_WIDTH-1:0]   w_stored;
  logic [ACTION_WIDTH-1:0]   w_action;
  logic [63:0]               w_cnt_next;
  logic [AW-1:0]             w_slot_base;
  logic w_empty, w_full, w_nearly_full, w_pop, w_win, w_verdict, w_take, w_last, w_hit;
  fallthrough_small_fifo #(.WIDTH(QW), .MAX_DEPTH_BITS(2)) u_fifo (
    .clk(clk), .rst_n(rst_n), .i_din({i_flow_entry, i_pkt_size}), .i_wr_en(i_flow_entry_vld),
    .i_rd_en(w_pop), .o_dout(w_dout), .o_full(w_full), .o_nearly_full(w_nearly_full), .o_empty(w_empty)
  );
  assign {w_entry, w_pkt_size} = w_dout;
  assign o_exact_match_rdy = !w_nearly_full;
  assign w_slot_base = AW'({flow_hash((HASH_WIDTH*HASH_CHUNKS)'(w_entry)), 4'b0000});
  assign w_take   = i_rd_0_vld && (r_state == S_READ || r_state == S_WAIT_DATA);
  assign w_last   = w_take && r_rsp_cnt == 4'(READ_WORDS - 1);
  assign w_stored = {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
  // The final returned word is the top action word, so the rest of the slot is already captured
  assign w_hit    = r_slot[WORD_STAT][VALID_BIT] && w_stored == (4*DATA_WIDTH)'(w_entry);
  assign w_action = ACTION_WIDTH'({i_rd_0_data[DATA_WIDTH-1:0], r_slot[9], r_slot[8], r_slot[7], r_slot[6]});
  assign w_cnt_next = {r_slot[WORD_CNT][63:32] + 32'd1, r_slot[WORD_CNT][31:0] + 32'(w_pkt_size)};
  assign w_win     = i_exact_wins && !i_exact_loses;
  assign w_verdict = i_exact_wins || i_exact_loses;
  assign w_pop = ((r_state == S_RESULT || r_state == S_WAIT_ARB) && w_verdict && !(w_win && r_hit)) ||
                 (r_state == S_WRITE && o_wr_0_req && i_wr_0_ack && r_wr_idx);
  always_ff @(posedge clk)
    if (w_take) r_slot[r_rsp_cnt] <= i_rd_0_data[DATA_WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_req_cnt        <= '0;
      r_rsp_cnt        <= '0;
      r_hit            <= 1'b0;
      r_wr_idx         <= 1'b0;
      r_base           <= '0;
      o_exact_hit      <= 1'b0;
      o_exact_miss     <= 1'b0;
      o_exact_data     <= '0;
      o_exact_data_vld <= 1'b0;
      o_rd_0_req       <= 1'b0;
      o_rd_0_addr      <= '0;
      o_wr_0_req       <= 1'b0;
      o_wr_0_addr      <= '0;
      o_wr_0_data      <= '0;
    end else begin
      o_exact_hit      <= 1'b0;
      o_exact_miss     <= 1'b0;
      o_exact_data_vld <= 1'b0;
      if (w_take) r_rsp_cnt <= r_rsp_cnt + 4'd1;
      case (r_state)
        S_IDLE: if (!w_empty) begin
          r_state     <= S_READ;
          o_rd_0_req  <= 1'b1;
          o_rd_0_addr <= w_slot_base;
          r_base      <= w_slot_base;
          r_req_cnt   <= '0;
          r_rsp_cnt   <= '0;
        end
        S_READ: if (i_rd_0_ack) begin
          o_rd_0_addr <= o_rd_0_addr + AW'(1);
          r_req_cnt   <= r_req_cnt + 4'd1;
          if (r_req_cnt == 4'(READ_WORDS - 1)) begin
            o_rd_0_req <= 1'b0;
            r_state    <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: ;
        S_RESULT, S_WAIT_ARB: if (!w_verdict) r_state <= S_WAIT_ARB;
          else if (w_win && r_hit) begin
            r_state     <= S_WRITE;
            r_wr_idx    <= 1'b0;
            o_wr_0_req  <= 1'b1;
            o_wr_0_addr <= r_base + AW'(WORD_CNT);
            o_wr_0_data <= {{CTRL_WIDTH{1'b0}}, w_cnt_next};
          end else r_state <= S_IDLE;
        S_WRITE: if (i_wr_0_ack) begin
          if (r_wr_idx) begin
            o_wr_0_req <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_wr_idx    <= 1'b1;
            o_wr_0_addr <= r_base + AW'(WORD_STAT);
            o_wr_0_data <= {{CTRL_WIDTH{1'b0}}, 1'b1, 31'b0, i_openflow_timer};
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_last) begin
        r_state          <= S_RESULT;
        r_hit            <= w_hit;
        o_exact_hit      <= w_hit;
        o_exact_miss     <= !w_hit;
        o_exact_data_vld <= 1'b1;
        o_exact_data     <= w_hit ? w_action : '0;
      end
    end
endmodule

// File: tb/tb_exact_match_lookup.sv
// tb_exact_match_lookup: directed checks of lookup, verdict, write-back, back-pressure and reset
module tb_exact_match_lookup;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [247:0] i_flow_entry = '0;
  logic         i_flow_entry_vld = 1'b0;
  logic [11:0]  i_pkt_size = '0;
  logic         o_exact_match_rdy, o_exact_hit, o_exact_miss, o_exact_data_vld;
  logic [319:0] o_exact_data;
  logic         i_exact_wins = 1'b0, i_exact_loses = 1'b0;
  logic [31:0]  i_openflow_timer = '0;
  logic         o_rd_0_req, i_rd_0_ack = 1'b0, i_rd_0_vld = 1'b0;
  logic [18:0]  o_rd_0_addr, o_wr_0_addr;
  logic [71:0]  i_rd_0_data = '0, o_wr_0_data;
  logic         o_wr_0_req, i_wr_0_ack = 1'b0;
  exact_match_lookup dut (
    .clk(clk), .rst_n(rst_n), .i_flow_entry(i_flow_entry), .i_flow_entry_vld(i_flow_entry_vld),
    .i_pkt_size(i_pkt_size), .o_exact_match_rdy(o_exact_match_rdy), .o_exact_hit(o_exact_hit),
    .o_exact_miss(o_exact_miss), .o_exact_data(o_exact_data), .o_exact_data_vld(o_exact_data_vld),
    .i_exact_wins(i_exact_wins), .i_exact_loses(i_exact_loses), .i_openflow_timer(i_openflow_timer),
    .o_rd_0_req(o_rd_0_req), .o_rd_0_addr(o_rd_0_addr), .i_rd_0_ack(i_rd_0_ack), .i_rd_0_vld(i_rd_0_vld),
    .i_rd_0_data(i_rd_0_data), .o_wr_0_req(o_wr_0_req), .o_wr_0_addr(o_wr_0_addr),
    .o_wr_0_data(o_wr_0_data), .i_wr_0_ack(i_wr_0_ack)
  );
  int n_checks = 0, n_pass = 0, pulses = 0, both = 0;
  logic [71:0] mem [int];
  int          rd_q[$];
  int          rd_log[$];
  logic [18:0] wr_addr_q[$];
  logic [71:0] wr_data_q[$];
  bit          ack_en = 1'b1;
  logic [247:0] e_key;
  logic [319:0] act;
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [71:0] rd_word(input int a);
    return mem.exists(a) ? mem[a] : 72'h0;
  endfunction
  // SRAM model: one-cycle read latency, ack gated by ack_en, writes always acked
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rd_q.delete();
      i_rd_0_ack = 1'b0;
      i_rd_0_vld = 1'b0;
      i_wr_0_ack = 1'b0;
    end else begin
      if (rd_q.size() > 0) begin
        i_rd_0_vld  = 1'b1;
        i_rd_0_data = rd_word(rd_q.pop_front());
      end else begin
        i_rd_0_vld  = 1'b0;
        i_rd_0_data = '0;
      end
      i_rd_0_ack = ack_en && o_rd_0_req;
      if (i_rd_0_ack) begin
        rd_q.push_back(int'(o_rd_0_addr));
        rd_log.push_back(int'(o_rd_0_addr));
      end
      i_wr_0_ack = o_wr_0_req;
      if (i_wr_0_ack) begin
        wr_addr_q.push_back(o_wr_0_addr);
        wr_data_q.push_back(o_wr_0_data);
        mem[int'(o_wr_0_addr)] = o_wr_0_data;
      end
      if (o_exact_data_vld) pulses++;
      if (o_exact_hit && o_exact_miss) both++;
    end
  end
  task automatic set_slot(input int base, input logic [247:0] e, input logic [31:0] pc, input logic [31:0] bc,
                          input logic v, input logic [319:0] a);
    logic [255:0] ee;
    ee = {8'h00, e};
    for (int i = 0; i < 4; i++) mem[base+i] = {8'hA5, ee[i*64 +: 64]};
    mem[base+4] = {8'hA5, pc, bc};
    mem[base+5] = {8'hA5, v, 31'b0, 32'd0};
    for (int i = 0; i < 5; i++) mem[base+6+i] = {8'hA5, a[i*64 +: 64]};
  endtask
  task automatic request(input logic [247:0] e, input logic [11:0] sz);
    i_flow_entry = e;
    i_pkt_size = sz;
    i_flow_entry_vld = 1'b1;
    @(negedge clk);
    i_flow_entry_vld = 1'b0;
  endtask
  task automatic wait_result(output logic h, output logic m, output logic [319:0] d);
    int n = 0;
    while (!o_exact_data_vld && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("result_seen", 320'(o_exact_data_vld), 320'd1);
    h = o_exact_hit;
    m = o_exact_miss;
    d = o_exact_data;
  endtask
  task automatic verdict(input logic w, input logic l);
    i_exact_wins = w;
    i_exact_loses = l;
    @(negedge clk);
    i_exact_wins = 1'b0;
    i_exact_loses = 1'b0;
  endtask
  task automatic wait_writes(input int n);
    int k = 0;
    while (wr_addr_q.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("write_count", 320'(wr_addr_q.size()), 320'(n));
  endtask
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic h, m;
    logic [319:0] d;
    logic exp_hit [3];
    int p0;
    e_key = (248'd1 << 247) | (248'd5 << 15) | 248'd3;
    act = {64'h4444_0000_0000_0044, 64'h3333_0000_0000_0033, 64'h2222_0000_0000_0022,
           64'h1111_0000_0000_0011, 64'h0000_0000_0000_0F0F};
    idle_cycles(3);
    check("rst_rdy", 320'(o_exact_match_rdy), 320'd1);
    check("rst_rd_req", 320'(o_rd_0_req), 320'd0);
    check("rst_wr_req", 320'(o_wr_0_req), 320'd0);
    check("rst_flags", 320'({o_exact_hit, o_exact_miss, o_exact_data_vld}), 320'd0);
    check("rst_data", o_exact_data, 320'd0);
    check("rst_addr", 320'({o_rd_0_addr, o_wr_0_addr}), 320'd0);
    rst_n = 1'b1;
    idle_cycles(2);
    // miss on an empty table: entry 1 hashes to slot base 0x10
    rd_log.delete();
    request(248'd1, 12'd64);
    wait_result(h, m, d);
    check("miss_flag", 320'({h, m}), 320'b01);
    check("miss_data", d, 320'd0);
    verdict(1'b0, 1'b1);
    idle_cycles(30);
    check("miss_rd_count", 320'(rd_log.size()), 320'd11);
    check("miss_rd_first", 320'(rd_log[0]), 320'h10);
    check("miss_rd_last", 320'(rd_log[10]), 320'h1A);
    check("miss_no_write", 320'(wr_addr_q.size()), 320'd0);
    // hit with winning verdict: e_key hashes to 3^5^0x80 = 0x86, base 0x860
    set_slot(32'h860, e_key, 32'd5, 32'd1000, 1'b1, act);
    i_openflow_timer = 32'd77;
    request(e_key, 12'd100);
    wait_result(h, m, d);
    check("hit_flag", 320'({h, m}), 320'b10);
    check("hit_data", d, act);
    idle_cycles(3);
    verdict(1'b1, 1'b0);
    wait_writes(2);
    check("hit_w0_addr", 320'(wr_addr_q[0]), 320'h864);
    check("hit_w0_data", 320'(wr_data_q[0]), 320'({8'h00, 32'd6, 32'd1100}));
    check("hit_w1_addr", 320'(wr_addr_q[1]), 320'h865);
    check("hit_w1_data", 320'(wr_data_q[1]), 320'({8'h00, 1'b1, 31'b0, 32'd77}));
    check("hit_wr_idle", 320'(o_wr_0_req), 320'd0);
    // hit with loses, then wins+loses together, both mean no write-back
    for (int v = 0; v < 2; v++) begin
      wr_addr_q.delete();
      wr_data_q.delete();
      set_slot(32'h860, e_key, 32'd5, 32'd1000, 1'b1, act);
      request(e_key, 12'd100);
      wait_result(h, m, d);
      check("lose_hit_flag", 320'({h, m}), 320'b10);
      verdict(v == 1, 1'b1);
      idle_cycles(30);
      check("lose_no_write", 320'(wr_addr_q.size()), 320'd0);
    end
    // counter wrap-around
    set_slot(32'h860, e_key, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, act);
    request(e_key, 12'h020);
    wait_result(h, m, d);
    check("wrap_hit_flag", 320'({h, m}), 320'b10);
    verdict(1'b1, 1'b0);
    wait_writes(2);
    check("wrap_w0_data", 320'(wr_data_q[0]), 320'({8'h00, 32'd0, 32'h10}));
    // back-pressure: stalled reads, three queued requests
    wr_addr_q.delete();
    wr_data_q.delete();
    set_slot(32'h860, e_key, 32'd5, 32'd1000, 1'b1, act);
    ack_en = 1'b0;
    request(248'd1, 12'd64);
    check("bp_rdy_1", 320'(o_exact_match_rdy), 320'd1);
    request(e_key, 12'd64);
    check("bp_rdy_2", 320'(o_exact_match_rdy), 320'd1);
    request(248'd2, 12'd64);
    check("bp_rdy_3", 320'(o_exact_match_rdy), 320'd0);
    ack_en = 1'b1;
    exp_hit = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      wait_result(h, m, d);
      check($sformatf("bp_order_%0d", i), 320'({h, m}), 320'({exp_hit[i], !exp_hit[i]}));
      check($sformatf("bp_data_%0d", i), d, exp_hit[i] ? act : 320'd0);
      verdict(1'b0, 1'b1);
    end
    idle_cycles(5);
    check("bp_rdy_after", 320'(o_exact_match_rdy), 320'd1);
    // asynchronous reset while reads are outstanding
    ack_en = 1'b0;
    request(248'd1, 12'd64);
    idle_cycles(3);
    check("rst_mid_req_before", 320'(o_rd_0_req), 320'd1);
    p0 = pulses;
    #2 rst_n = 1'b0;
    #1 check("rst_mid_req_async", 320'(o_rd_0_req), 320'd0);
    idle_cycles(2);
    #2 rst_n = 1'b1;
    ack_en = 1'b1;
    idle_cycles(30);
    check("rst_mid_no_pulse", 320'(pulses), 320'(p0));
    check("rst_mid_rdy", 320'(o_exact_match_rdy), 320'd1);
    check("rst_mid_rd_idle", 320'(o_rd_0_req), 320'd0);
    check("rst_mid_no_write", 320'(wr_addr_q.size()), 320'd0);
    check("hit_miss_exclusive", 320'(both), 320'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/exact_match_lookup.md
# exact_match_lookup

Exact-match flow table engine for the OpenFlow output-port-lookup stage. It takes parsed flow entries from the header parser and hashes each one to an SRAM slot. It reads the stored entry, counters and action, then reports hit or miss with the action to the match arbiter. If the arbiter selects an exact hit, it writes updated packet/byte counters and the last-seen timestamp back to SRAM.

## Interface
Parameters:
- ENTRY_WIDTH, 248: flow entry width.
- ACTION_WIDTH, 320: action width.
- PKT_SIZE_WIDTH, 12: packet size field width, in bytes.
- SRAM_ADDR_WIDTH, 19: SRAM word address width.
- DATA_WIDTH, 64 and CTRL_WIDTH, 8: SRAM word is 72 bits, {ctrl, data}.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- flow_entry  in  ENTRY_WIDTH  parsed entry; sampled when flow_entry_vld is high.
- flow_entry_vld  in  1  one-cycle lookup request.
- pkt_size  in  PKT_SIZE_WIDTH  sampled with flow_entry.
- exact_match_rdy  out  1  a new request can be accepted.
- exact_hit, exact_miss  out  1  one-cycle result pulses; mutually exclusive.
- exact_data  out  ACTION_WIDTH  action on hit, zero on miss; valid with exact_data_vld.
- exact_data_vld  out  1  one-cycle pulse, coincident with the hit/miss pulse.
- exact_wins, exact_loses  in  1  arbiter verdict for the current result.
- openflow_timer  in  32  seconds counter.
- rd_0_req, rd_0_addr  out  1 / SRAM_ADDR_WIDTH  read request.
- rd_0_ack  in  1  read request accepted.
- rd_0_vld, rd_0_data  in  1 / 72  read data return.
- wr_0_req, wr_0_addr, wr_0_data  out  1 / SRAM_ADDR_WIDTH / 72  write request.
- wr_0_ack  in  1  write request accepted.

## Operation
- **Request queue.** Each request {flow_entry, pkt_size} is pushed into a 4-deep fall-through FIFO. exact_match_rdy = !nearly_full, where nearly_full means at most 1 slot is free.
- **Hash.** Zero-extend the entry to 270 bits. XOR all eighteen 15-bit chunks together to form h[14:0].
- **Slot.** Each slot is 16 words at base {h, 4'b0000}. Only data bits are used; ctrl is ignored on read and written as 0.
- **Slot layout:**
  - Words 0–3: entry bits [63:0], [127:64], [191:128], [255:192]. Stored bits 255:248 are zero.
  - Word 4: {pkt_count[31:0], byte_count[31:0]}.
  - Word 5: {valid, 31'b0, last_seen[31:0]}.
  - Words 6–10: action bits [63:0] through [319:256].
- **State machine.** States are IDLE → READ → WAIT_DATA → RESULT → WAIT_ARB → WRITE → IDLE.
  - IDLE: move to READ when the FIFO is not empty.
  - READ: issue reads of words 0–10.
  - WAIT_DATA: collect all 11 returned words.
  - RESULT: hit = valid && stored entry == request entry. Pulse hit or miss together with exact_data_vld.
  - WAIT_ARB: wait for exact_wins or exact_loses. If exact_wins and hit, go to WRITE. Otherwise pop the FIFO and return to IDLE.
  - WRITE: write word 4 = {pkt_count+1, byte_count+pkt_size}, then word 5 = {1, 31'b0, openflow_timer}. Then pop the FIFO and return to IDLE.
- **Arithmetic.** Counters wrap modulo 2^32. pkt_size is zero-extended before the byte-count add.
- **Arbiter verdict.** exact_wins and exact_loses asserted in the same cycle is treated as loses.

## Timing
- **Reset values.** All req, hit/miss and vld outputs are 0. exact_data = 0, addresses = 0, exact_match_rdy = 1, FIFO empty, state IDLE.
- **Reset mid-operation.** Abandons the lookup, empties the FIFO and deasserts requests asynchronously. Nothing is written back.
- **Read handshake.** rd_0_req stays high with a stable address until rd_0_ack. On each ack the address advances by 1. After the 11th ack, rd_0_req drops in the next cycle. Back-to-back acks give one word per cycle.
- **Read data.** rd_0_vld words return in request order with arbitrary latency. Data may return while requests are still outstanding.
- **Result latency.** The hit/miss pulse occurs 1 cycle after the 11th rd_0_vld.
- **Verdict timing.** exact_wins/loses are accepted in the same cycle as the result pulse or any later cycle.
- **Write handshake.** Same rule as reads: wr_0_req is held until wr_0_ack, and each write is 1 word.
- **Ordering.** One lookup is in flight at a time. Results are in request order.
- **Pushes.** A push while the FIFO is full is dropped. Upstream must honour exact_match_rdy.

## Structure
- Shared package holds:
  - ENTRY_WIDTH and ACTION_WIDTH.
  - Slot word offsets: ENTRY 0, CNT 4, STAT 5, ACTION 6, SLOT_WORDS 16, READ_WORDS 11.
  - Valid-bit position.
- Sub-module fallthrough_small_fifo is the request queue: parameters WIDTH and MAX_DEPTH_BITS=2, with dout valid while not empty.

## Test plan
- **Miss.** SRAM all zero, entry=1, pkt_size=64 → exact_miss and exact_data_vld pulse together, exact_data=0. After exact_loses there is no wr_0_req.
- **Hit with winning verdict.**
  - Setup: slot for entry E holds E, counters {5, 1000}, valid=1, action=A; openflow_timer=77.
  - Action: request E with pkt_size=100, then drive exact_wins.
  - Required: exact_hit with exact_data=A; then word 4 is written as {6, 1100} and word 5 as {1, 0, 77}.
- **Hit with losing verdict.** Same setup, drive exact_loses → no writes.
- **Wrap-around.** pkt_count=FFFF_FFFF, byte_count=FFFF_FFF0, pkt_size=0x20 → writes {0, 0x10}.
- **Back-pressure.** Stall rd_0_ack, send 3 requests → exact_match_rdy falls after the 3rd. Three results then arrive in order.
- **Async reset during READ.** Assert reset during READ → rd_0_req is 0 immediately, no result pulse, and exact_match_rdy=1 after release.
